// File: rtl/atomrvcore_boot_pkg.sv
// Shared types and constants for the ICCM boot loader: FSM state encoding
// and the byte-lane geometry of a 32-bit word.
package atomrvcore_boot_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } boot_state_e;

    // States in which the loader is willing to take a stream byte.
    function automatic logic accepts_bytes(input boot_state_e s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/atomrvcore_boot_loader_if.sv
// Byte-stream input and ICCM write port of the boot loader.
// The loader side uses the slave modport; the stream source / ICCM side uses master.
interface atomrvcore_boot_loader_if #(
    parameter int DATAWIDTH = 32
);
    logic [7:0]           byte_i;
    logic                 byte_valid_i;
    logic                 byte_ready_o;
    logic [DATAWIDTH-1:0] iccm_data_o;
    logic [DATAWIDTH-1:0] iccm_addr_o;
    logic                 iccm_wr_en_o;

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, iccm_data_o, iccm_addr_o, iccm_wr_en_o
    );

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, iccm_data_o, iccm_addr_o, iccm_wr_en_o
    );
endinterface

// File: rtl/atomrvcore_byte_packer.sv
// Little-endian 4-byte assembler: the first byte of a group lands in bits [7:0].
// word_valid_o/word_o are combinational so the owner can react on the 4th byte.
module atomrvcore_byte_packer
    import atomrvcore_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_en_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  idx_q, idx_d;
    logic [23:0] sr_q, sr_d;

    assign word_valid_o = byte_en_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, sr_q};

    // Shift in accepted bytes; the index wraps so every field starts at lane 0.
    always_comb begin
        idx_d = idx_q;
        sr_d  = sr_q;
        if (byte_en_i) begin
            sr_d  = {byte_i, sr_q[23:8]};
            idx_d = idx_q + 2'd1;
        end else begin
            sr_d  = sr_q;
            idx_d = idx_q;
        end
    end

    // Packer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            idx_q <= idx_d;
            sr_q  <= sr_d;
        end
    end
endmodule

// File: rtl/atomrvcore_boot_loader.sv
// Byte-stream program loader: fills the ICCM, then releases the core reset once.
// Optional trailing checksum word enabled by ATOMRV_BOOT_CHECKSUM_EN.
module atomrvcore_boot_loader
    import atomrvcore_boot_pkg::*;
#(
    parameter int                   DATAWIDTH  = 32,
    parameter int                   ICCM_WORDS = 1024,
    parameter logic [DATAWIDTH-1:0] BASE_ADDR  = 32'h0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    atomrvcore_boot_loader_if.slave           bus,
    output logic                              core_rst_o,
    output logic                              done_o,
    output logic                              error_o,
    output logic [$clog2(ICCM_WORDS+1)-1:0]   words_loaded_o
);
    localparam int          WLW     = $clog2(ICCM_WORDS + 1);
    localparam logic [31:0] MAX_LEN = 32'(ICCM_WORDS);
`ifdef ATOMRV_BOOT_CHECKSUM_EN
    localparam boot_state_e S_FIN = S_CSUM;
`else
    localparam boot_state_e S_FIN = S_DONE;
`endif

    boot_state_e          state_q, state_d;
    logic [31:0]          len_q, len_d;
    logic [WLW-1:0]       wl_q, wl_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [DATAWIDTH-1:0] addr_q, addr_d;
    logic                 ready_q, ready_d;
    logic                 wr_en_q, wr_en_d;
    logic                 core_rst_q, core_rst_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
    logic [31:0]          sum_q, sum_d;
`endif

    logic        xfer_s;
    logic        pk_valid_s;
    logic [31:0] pk_word_s;

    assign xfer_s = bus.byte_valid_i & ready_q;

    atomrvcore_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (bus.byte_i),
        .byte_en_i    (xfer_s),
        .word_valid_o (pk_valid_s),
        .word_o       (pk_word_s)
    );

    // Next-state logic; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wl_d    = wl_q;
        data_d  = data_q;
        addr_d  = addr_q;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_LEN: begin
                if (pk_valid_s) begin
                    len_d = pk_word_s;
                    if (pk_word_s == 32'd0) begin
                        state_d = S_FIN;
                    end else if (pk_word_s > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (pk_valid_s) begin
                    data_d  = pk_word_s;
                    addr_d  = BASE_ADDR + DATAWIDTH'({wl_q, 2'b00});
                    state_d = S_WRITE;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
                    sum_d   = sum_q + pk_word_s;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                wl_d = wl_q + {{(WLW-1){1'b0}}, 1'b1};
                if (32'(wl_d) == len_q) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef ATOMRV_BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (pk_valid_s) begin
                    state_d = (pk_word_s == sum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        ready_d    = accepts_bytes(state_d);
        wr_en_d    = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        core_rst_d = (state_d != S_DONE);
    end

    // State and registered outputs; reset wins over any same-cycle transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_LEN;
            len_q      <= 32'd0;
            wl_q       <= '0;
            data_q     <= '0;
            addr_q     <= BASE_ADDR;
            ready_q    <= 1'b1;
            wr_en_q    <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wl_q       <= wl_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            wr_en_q    <= wr_en_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.iccm_wr_en_o = wr_en_q;
    assign bus.iccm_data_o  = data_q;
    assign bus.iccm_addr_o  = addr_q;
    assign core_rst_o       = core_rst_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign words_loaded_o   = wl_q;
endmodule

// File: tb/tb_atomrvcore_boot_loader.sv
// Scoreboard bench for the boot loader: stimulus pushes expected ICCM writes,
// a negedge monitor pops and compares them whenever iccm_wr_en_o is high.
module tb_atomrvcore_boot_loader;
    localparam int ICCM_WORDS = 1024;
    localparam int WLW        = $clog2(ICCM_WORDS + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           core_rst, done, err;
    logic [WLW-1:0] wl;

    always #5 clk = ~clk;

    atomrvcore_boot_loader_if #(.DATAWIDTH(32)) bus ();

    atomrvcore_boot_loader #(
        .DATAWIDTH  (32),
        .ICCM_WORDS (ICCM_WORDS),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus.slave),
        .core_rst_o     (core_rst),
        .done_o         (done),
        .error_o        (err),
        .words_loaded_o (wl)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } wr_t;

    wr_t  exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   gaps    = 1'b0;
    logic prev_wr = 1'b0;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
    logic [31:0] img_sum = 32'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strike must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (!rst && bus.iccm_wr_en_o) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected",
                         bus.iccm_addr_o, bus.iccm_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_data", bus.iccm_data_o, e.data);
                check("wr_addr", bus.iccm_addr_o, e.addr);
            end
            check("wr_one_cycle", {31'd0, prev_wr}, 32'd0);
        end
        prev_wr = bus.iccm_wr_en_o && !rst;
    end

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.byte_valid_i = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            acc = bus.byte_ready_o;
            @(posedge clk); #1;
            if (acc) break;
        end
        bus.byte_valid_i = 1'b0;
        check("byte_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    // Data word that the loader must write to word slot idx.
    task automatic send_data(input logic [31:0] w, input int idx);
        wr_t e;
        e.data = w;
        e.addr = 32'(idx) * 32'd4;
        exp_q.push_back(e);
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        img_sum = img_sum + w;
`endif
        send_word(w);
    endtask

    task automatic finish_image();
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        send_word(img_sum);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.byte_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        img_sum = 32'd0;
`endif
        check("rst_ready",    {31'd0, bus.byte_ready_o}, 32'd1);
        check("rst_wr_en",    {31'd0, bus.iccm_wr_en_o}, 32'd0);
        check("rst_addr",     bus.iccm_addr_o, 32'h0);
        check("rst_data",     bus.iccm_data_o, 32'h0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done",     {31'd0, done}, 32'd0);
        check("rst_error",    {31'd0, err}, 32'd0);
        check("rst_words",    32'(wl), 32'd0);
    endtask

    task automatic settle_and_check_done(input int words);
        repeat (2) @(posedge clk);
        #1;
        check("done",      {31'd0, done}, 32'd1);
        check("core_rel",  {31'd0, core_rst}, 32'd0);
        check("err_clear", {31'd0, err}, 32'd0);
        check("words",     32'(wl), 32'(words));
        check("drained",   32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] t1_bytes [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                  8'h13, 8'h05, 8'h10, 8'h00,
                                  8'h93, 8'h05, 8'h20, 8'h00};

    initial begin
        wr_t e;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Two-word image from a literal byte table, valid held high.
        e.data = 32'h00100513; e.addr = 32'h0; exp_q.push_back(e);
        e.data = 32'h00200593; e.addr = 32'h4; exp_q.push_back(e);
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        img_sum = 32'h00100513 + 32'h00200593;
`endif
        for (int i = 0; i < 12; i++) send_byte(t1_bytes[i]);
`ifdef ATOMRV_BOOT_CHECKSUM_EN
        finish_image();
        check("t1_done_now", {31'd0, done}, 32'd1);
        check("t1_core_rel", {31'd0, core_rst}, 32'd0);
`else
        check("t1_wr_pulse", {31'd0, bus.iccm_wr_en_o}, 32'd1);
        check("t1_ready_lo", {31'd0, bus.byte_ready_o}, 32'd0);
        check("t1_not_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("t1_done_next", {31'd0, done}, 32'd1);
        check("t1_core_rel",  {31'd0, core_rst}, 32'd0);
`endif
        settle_and_check_done(2);
        // Extra bytes after completion are refused.
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check("done_ready_lo", {31'd0, bus.byte_ready_o}, 32'd0);
        check("done_words",    32'(wl), 32'd2);
        bus.byte_valid_i = 1'b0;

        // Empty image.
        do_reset();
        send_word(32'd0);
        finish_image();
        check("l0_done_now", {31'd0, done}, 32'd1);
        settle_and_check_done(0);

        // Oversized length is rejected.
        do_reset();
        send_word(32'd1025);
        check("big_error",    {31'd0, err}, 32'd1);
        check("big_core_rst", {31'd0, core_rst}, 32'd1);
        check("big_ready",    {31'd0, bus.byte_ready_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("big_words", 32'(wl), 32'd0);
        check("big_done",  {31'd0, done}, 32'd0);

        // Three words with random valid gaps.
        do_reset();
        gaps = 1'b1;
        send_word(32'd3);
        send_data(32'h00000013, 0);
        send_data(32'h12345678, 1);
        send_data(32'hCAFEF00D, 2);
        finish_image();
        gaps = 1'b0;
        settle_and_check_done(3);

        // Reset after 5 data bytes, then a fresh one-word image.
        do_reset();
        send_word(32'd3);
        send_data(32'hA5A55A5A, 0);
        send_byte(8'h77);
        do_reset();
        send_word(32'd1);
        send_data(32'h00000093, 0);
        finish_image();
        settle_and_check_done(1);

        // Largest legal image fills every ICCM word.
        do_reset();
        send_word(32'(ICCM_WORDS));
        for (int i = 0; i < ICCM_WORDS; i++) send_data(32'h1000_0000 + 32'(i), i);
        finish_image();
        settle_and_check_done(ICCM_WORDS);
        check("full_last_addr", bus.iccm_addr_o, 32'h0000_0FFC);

`ifdef ATOMRV_BOOT_CHECKSUM_EN
        // Checksum match and mismatch.
        do_reset();
        send_word(32'd2);
        send_data(32'd1, 0);
        send_data(32'd2, 1);
        send_word(32'd3);
        check("cs_ok_done", {31'd0, done}, 32'd1);
        settle_and_check_done(2);
        do_reset();
        send_word(32'd2);
        send_data(32'd1, 0);
        send_data(32'd2, 1);
        send_word(32'd4);
        check("cs_bad_err",  {31'd0, err}, 32'd1);
        check("cs_bad_core", {31'd0, core_rst}, 32'd1);
        check("cs_bad_done", {31'd0, done}, 32'd0);
`endif

        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
